// File: rtl/gyro_heading_integrator.sv
// gyro_heading_integrator
// Assembles signed 16-bit Z-rate samples from the gyro byte stream (MSB then
// LSB), averages the first 2^CALIB_LOG2 samples into a zero-rate bias, then
// integrates bias-corrected, saturated rate into a wrapping heading.
// Optional build macro: GYRO_DEADBAND_EN forces |rate| <= DEADBAND to zero.
module gyro_heading_integrator #(
  parameter int CALIB_LOG2 = 4,
  parameter int ACC_W      = 32,
  parameter int DEADBAND   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  input  logic             frame_start_i,
  input  logic             zero_heading_i,
  output logic [15:0]      rate_out_o,
  output logic [ACC_W-1:0] heading_o,
  output logic             heading_valid_o,
  output logic             calib_done_o,
  output logic             byte_err_o
);

  localparam int SUM_W = 16 + CALIB_LOG2;

  typedef enum logic { WAIT_MSB = 1'b0, WAIT_LSB = 1'b1 } asm_state_e;
  typedef enum logic { CALIB = 1'b0, RUN = 1'b1 } main_state_e;

  // Byte assembler state
  asm_state_e       asm_state_q;
  logic [7:0]       msb_q;
  logic [15:0]      word_q;
  logic             word_vld_q;
  logic             byte_err_q;

  // Calibration / integration state
  main_state_e             main_state_q;
  logic signed [SUM_W-1:0] sum_q;
  logic [CALIB_LOG2-1:0]   cnt_q;
  logic [15:0]             bias_q;
  logic [15:0]             rate_q;
  logic [ACC_W-1:0]        heading_q;
  logic                    heading_valid_q;
  logic                    calib_done_q;

  // Combinational datapath results
  logic signed [SUM_W-1:0] sum_d;
  logic [15:0]             bias_d;
  logic [16:0]             diff_s;
  logic [15:0]             sat_s;
  logic [15:0]             rate_d;
  logic [ACC_W-1:0]        heading_d;

`ifdef GYRO_DEADBAND_EN
  logic [16:0]             mag_s;
`else
  logic [31:0]             unused_deadband_s;
  assign unused_deadband_s = 32'(DEADBAND);
`endif

  // Byte assembler FSM: pairs MSB/LSB bytes into words, flags framing errors
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_state_q <= WAIT_MSB;
      msb_q       <= 8'h00;
      word_q      <= 16'h0000;
      word_vld_q  <= 1'b0;
      byte_err_q  <= 1'b0;
    end else begin
      word_vld_q <= 1'b0;
      case (asm_state_q)
        WAIT_MSB: begin
          if (byte_valid_i) begin
            if (frame_start_i) begin
              msb_q       <= byte_data_i;
              asm_state_q <= WAIT_LSB;
            end else begin
              // stray LSB: drop the byte, remember the framing fault
              byte_err_q <= 1'b1;
            end
          end
        end
        WAIT_LSB: begin
          if (byte_valid_i) begin
            if (frame_start_i) begin
              // premature MSB restarts the frame with this byte
              byte_err_q <= 1'b1;
              msb_q      <= byte_data_i;
            end else begin
              word_q      <= {msb_q, byte_data_i};
              word_vld_q  <= 1'b1;
              asm_state_q <= WAIT_MSB;
            end
          end
        end
        default: asm_state_q <= WAIT_MSB;
      endcase
    end
  end

  // Bias sum, corrected/saturated rate and next heading for the current word
  always_comb begin
    sum_d     = sum_q + {{CALIB_LOG2{word_q[15]}}, word_q};
    bias_d    = 16'(sum_d >>> CALIB_LOG2);
    diff_s    = {word_q[15], word_q} - {bias_q[15], bias_q};
    sat_s     = diff_s[15:0];
    rate_d    = 16'h0000;
    heading_d = {ACC_W{1'b0}};
    case (diff_s[16:15])
      2'b01:   sat_s = 16'h7FFF;
      2'b10:   sat_s = 16'h8000;
      default: sat_s = diff_s[15:0];
    endcase
`ifdef GYRO_DEADBAND_EN
    if (sat_s[15]) begin
      mag_s = 17'h00000 - {1'b1, sat_s};
    end else begin
      mag_s = {1'b0, sat_s};
    end
    if (mag_s <= 17'(DEADBAND)) begin
      rate_d = 16'h0000;
    end else begin
      rate_d = sat_s;
    end
`else
    rate_d = sat_s;
`endif
    heading_d = heading_q + {{(ACC_W-16){rate_d[15]}}, rate_d};
  end

  // Main FSM: accumulate calibration samples, then integrate corrected rate
  always_ff @(posedge clk) begin
    if (rst) begin
      main_state_q    <= CALIB;
      sum_q           <= {SUM_W{1'b0}};
      cnt_q           <= {CALIB_LOG2{1'b0}};
      bias_q          <= 16'h0000;
      rate_q          <= 16'h0000;
      heading_q       <= {ACC_W{1'b0}};
      heading_valid_q <= 1'b0;
      calib_done_q    <= 1'b0;
    end else begin
      heading_valid_q <= 1'b0;
      case (main_state_q)
        CALIB: begin
          if (word_vld_q) begin
            sum_q <= sum_d;
            cnt_q <= cnt_q + CALIB_LOG2'(1);
            if (&cnt_q) begin
              bias_q       <= bias_d;
              calib_done_q <= 1'b1;
              main_state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (word_vld_q) begin
            rate_q          <= rate_d;
            heading_valid_q <= 1'b1;
            // a coincident zero request discards this sample's contribution
            heading_q       <= zero_heading_i ? {ACC_W{1'b0}} : heading_d;
          end else if (zero_heading_i) begin
            heading_q <= {ACC_W{1'b0}};
          end
        end
        default: main_state_q <= CALIB;
      endcase
    end
  end

  assign rate_out_o      = rate_q;
  assign heading_o       = heading_q;
  assign heading_valid_o = heading_valid_q;
  assign calib_done_o    = calib_done_q;
  assign byte_err_o      = byte_err_q;

endmodule

// File: tb/tb_gyro_heading_integrator.sv
// Directed self-checking bench for gyro_heading_integrator.
// Two instances share stimulus: default ACC_W=32 and ACC_W=17 for wrap checks.
module tb_gyro_heading_integrator;

  logic        clk = 1'b0;
  logic        rst;
  logic        bv;
  logic [7:0]  bd;
  logic        fs;
  logic        zh;

  logic [15:0] rate,  rate2;
  logic [31:0] head;
  logic [16:0] head2;
  logic        hv, hv2, cd, cd2, be, be2;

  int n_chk  = 0;
  int n_fail = 0;
  int hv_cnt = 0;

  always #5 clk = ~clk;

  gyro_heading_integrator #(.CALIB_LOG2(4), .ACC_W(32), .DEADBAND(8)) dut (
    .clk(clk), .rst(rst), .byte_valid_i(bv), .byte_data_i(bd),
    .frame_start_i(fs), .zero_heading_i(zh),
    .rate_out_o(rate), .heading_o(head), .heading_valid_o(hv),
    .calib_done_o(cd), .byte_err_o(be));

  gyro_heading_integrator #(.CALIB_LOG2(4), .ACC_W(17), .DEADBAND(8)) dut17 (
    .clk(clk), .rst(rst), .byte_valid_i(bv), .byte_data_i(bd),
    .frame_start_i(fs), .zero_heading_i(zh),
    .rate_out_o(rate2), .heading_o(head2), .heading_valid_o(hv2),
    .calib_done_o(cd2), .byte_err_o(be2));

  // count heading_valid pulses of the main instance
  always @(posedge clk) begin
    if (hv === 1'b1) hv_cnt <= hv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // MSB then LSB on consecutive cycles; returns at the negedge after the LSB edge
  task automatic send_word(input logic [15:0] w);
    @(negedge clk); bv = 1'b1; fs = 1'b1; bd = w[15:8];
    @(negedge clk); fs = 1'b0; bd = w[7:0];
    @(negedge clk); bv = 1'b0; bd = 8'h00;
  endtask

  task automatic do_sample(input string tag, input logic [15:0] w,
                           input logic [15:0] exp_rate, input logic [31:0] exp_head);
    send_word(w);
    chk({tag, "_hv_latency"}, {31'd0, hv}, 32'd0);
    @(negedge clk);
    chk({tag, "_hv"}, {31'd0, hv}, 32'd1);
    chk({tag, "_rate"}, {16'd0, rate}, {16'd0, exp_rate});
    chk({tag, "_heading"}, head, exp_head);
  endtask

  task automatic calibrate(input logic [15:0] w);
    int hv0;
    hv0 = hv_cnt;
    for (int i = 0; i < 16; i++) send_word(w);
    chk("calib_done_before_e1", {31'd0, cd}, 32'd0);
    @(negedge clk);
    chk("calib_done_rise", {31'd0, cd}, 32'd1);
    chk("calib_no_hv", 32'(hv_cnt - hv0), 32'd0);
    chk("calib_heading_zero", head, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bv = 1'b0; bd = 8'h00; fs = 1'b0; zh = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rate", {16'd0, rate}, 32'd0);
    chk("rst_heading", head, 32'd0);
    chk("rst_hv", {31'd0, hv}, 32'd0);
    chk("rst_calib_done", {31'd0, cd}, 32'd0);
    chk("rst_byte_err", {31'd0, be}, 32'd0);
    chk("rst_calib_done17", {31'd0, cd2}, 32'd0);
    rst = 1'b0;

    // calibration on 0x0010 -> bias 16
    calibrate(16'h0010);
    do_sample("pos", 16'h0110, 16'h0100, 32'd256);
    @(negedge clk);
    chk("pos_hv_one_cycle", {31'd0, hv}, 32'd0);

    // standalone zero request in RUN
    zh = 1'b1;
    @(negedge clk); zh = 1'b0;
    chk("zero_standalone", head, 32'd0);

    // negative accumulation
    do_sample("neg1", 16'hFF10, 16'hFF00, 32'hFFFFFF00);
    do_sample("neg2", 16'hFF10, 16'hFF00, 32'hFFFFFE00);
    do_sample("neg3", 16'hFF10, 16'hFF00, 32'hFFFFFD00);

    // small rate: deadband behaviour depends on build
`ifdef GYRO_DEADBAND_EN
    do_sample("deadband", 16'h0015, 16'h0000, 32'hFFFFFD00);
`else
    do_sample("deadband", 16'h0015, 16'h0005, 32'hFFFFFD05);
`endif

    // saturation with negative bias
    do_reset();
    chk("rst2_heading", head, 32'd0);
    calibrate(16'hFFF0);
    do_sample("sat", 16'h7FFF, 16'h7FFF, 32'd32767);

    // wrap on the 17-bit instance
    do_reset();
    calibrate(16'h0000);
    do_sample("wrap_a", 16'h7FFF, 16'h7FFF, 32'd32767);
    do_sample("wrap_b", 16'h7FFF, 16'h7FFF, 32'd65534);
    do_sample("wrap_c", 16'h0001, 16'h0001, 32'd65535);
    chk("wrap_c_h17", {15'd0, head2}, 32'h0FFFF);
    do_sample("wrap_d", 16'h0001, 16'h0001, 32'h00010000);
    chk("wrap_d_h17", {15'd0, head2}, 32'h10000);
    chk("wrap_d_rate17", {16'd0, rate2}, 32'h0001);

    // zero request on the update edge: zero wins, rate and pulse still update
    send_word(16'h0005);
    zh = 1'b1;
    @(negedge clk); zh = 1'b0;
    chk("zero_upd_hv", {31'd0, hv}, 32'd1);
    chk("zero_upd_rate", {16'd0, rate}, 32'h0005);
    chk("zero_upd_heading", head, 32'd0);
    chk("zero_upd_h17", {15'd0, head2}, 32'd0);

    // MSB, MSB, LSB: error flagged, second MSB used
    @(negedge clk); bv = 1'b1; fs = 1'b1; bd = 8'h12;
    @(negedge clk); bd = 8'h00;
    @(negedge clk); fs = 1'b0; bd = 8'h05;
    @(negedge clk); bv = 1'b0; bd = 8'h00;
    chk("dbl_msb_err", {31'd0, be}, 32'd1);
    @(negedge clk);
    chk("dbl_msb_hv", {31'd0, hv}, 32'd1);
    chk("dbl_msb_rate", {16'd0, rate}, 32'h0005);
    chk("dbl_msb_heading", head, 32'd5);

    // reset between MSB and LSB
    @(negedge clk); bv = 1'b1; fs = 1'b1; bd = 8'h12;
    @(negedge clk); bv = 1'b0; fs = 1'b0; bd = 8'h00; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_rate", {16'd0, rate}, 32'd0);
    chk("midrst_heading", head, 32'd0);
    chk("midrst_hv", {31'd0, hv}, 32'd0);
    chk("midrst_calib_done", {31'd0, cd}, 32'd0);
    chk("midrst_byte_err", {31'd0, be}, 32'd0);
    chk("midrst_byte_err17", {31'd0, be2}, 32'd0);

    // lone LSB after reset: error, no sample
    bv = 1'b1; fs = 1'b0; bd = 8'h34;
    @(negedge clk); bv = 1'b0; bd = 8'h00;
    chk("lsb_only_err", {31'd0, be}, 32'd1);
    @(negedge clk);
    chk("lsb_only_hv_a", {31'd0, hv}, 32'd0);
    @(negedge clk);
    chk("lsb_only_hv_b", {31'd0, hv}, 32'd0);
    chk("lsb_only_rate", {16'd0, rate}, 32'd0);
    chk("lsb_only_hv17", {31'd0, hv2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gyro_heading_integrator.md
# gyro_heading_integrator

Downstream consumer of the position sensor's I2C read path. Takes the byte stream read from the gyro's Z-rate register pair (MSB then LSB), assembles signed 16-bit rate samples, and estimates the zero-rate bias from the first 2^CALIB_LOG2 samples after reset. It then integrates bias-corrected rate into a wrapping heading accumulator for the navigation logic.

## Interface
- CALIB_LOG2, 4: log2 of calibration sample count (16 samples).
- ACC_W, 32: heading accumulator width; must be >= 17.
- DEADBAND, 8: magnitude at or below which corrected rate is forced to 0 (only with macro).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- byte_valid  in  1  one-cycle strobe; byte_data valid.
- byte_data  in  8  byte read from sensor.
- frame_start  in  1  qualifies byte_valid: this byte is a sample MSB.
- zero_heading  in  1  one-cycle request to clear heading.
- rate_out  out  16  signed corrected rate of last sample; reset 0.
- heading  out  ACC_W  signed accumulated heading; reset 0.
- heading_valid  out  1  one-cycle pulse when rate_out/heading update; reset 0.
- calib_done  out  1  high once bias is latched; reset 0.
- byte_err  out  1  sticky framing error; reset 0, cleared only by rst.

## Operation
- Byte assembler (2 states, WAIT_MSB / WAIT_LSB):
  - WAIT_MSB: byte_valid & frame_start -> latch MSB, go WAIT_LSB. byte_valid without frame_start -> byte dropped, byte_err set.
  - WAIT_LSB: byte_valid & !frame_start -> word = {MSB, byte}, go WAIT_MSB, sample strobe. byte_valid & frame_start -> byte_err set, byte taken as new MSB, stay WAIT_LSB.
- Main FSM (CALIB / RUN), entered in CALIB at reset:
  - CALIB: each sample sign-extended into (16+CALIB_LOG2)-bit sum; counter counts samples. At the 2^CALIB_LOG2-th sample: bias = sum >>> CALIB_LOG2 (arithmetic, truncation toward -inf), calib_done=1, go RUN. No heading_valid pulses in CALIB; heading stays 0.
  - RUN: diff = word - bias in 17 bits; saturate to [-32768, 32767] -> rate; deadband applied (see Configuration); heading += sign-extend(rate), wrapping modulo 2^ACC_W, no saturation.
- zero_heading: in RUN, heading <= 0 next edge. Coincident with a heading update edge: zero wins, that sample is not integrated, rate_out still updates, heading_valid still pulses (heading reads 0). Ignored in CALIB.
- rst at any point (mid-frame, mid-calibration) returns to WAIT_MSB/CALIB with all outputs and the bias cleared.

## Timing
- Edge E0: LSB byte_valid sampled; assembled word registered.
- Edge E0+1: rate_out and heading registered; heading_valid high for the cycle after E0+1.
- Latency: 2 clocks from the LSB byte_valid cycle to visible outputs.
- calib_done rises at E0+1 of the final calibration sample.
- Back-to-back bytes on consecutive cycles accepted; fully pipelined, no stall, no backpressure.

## Configuration
- GYRO_DEADBAND_EN defined: |rate| <= DEADBAND after saturation -> rate 0 (both rate_out and integration).
- Undefined: saturated rate passes unchanged; DEADBAND parameter unused.

## Test plan
- Calibration: 16 samples 0x0010 -> calib_done after 16th (E0+1), no heading_valid during CALIB, heading 0; then sample 0x0110 -> rate_out 0x0100, heading 256, heading_valid one cycle at latency 2.
- Negative / accumulation: bias 16, three samples 0xFF10 -> rate_out 0xFF00 each; heading -256, -512, -768.
- Saturation: calibrate on 0xFFF0 (bias -16), sample 0x7FFF -> rate_out 0x7FFF, heading 32767.
- Deadband: bias 16, sample 0x0015 -> rate_out 0, heading unchanged (with GYRO_DEADBAND_EN); without macro -> rate_out 5.
- Wrap / zero: ACC_W=17, heading 65535 + rate 1 -> heading 0x10000 (-65536); zero_heading on the update edge -> heading 0, heading_valid pulses.
- Framing / reset: LSB without prior MSB -> byte_err 1, no sample; rst asserted between MSB and LSB -> all outputs 0, calib_done 0, following LSB-only byte sets byte_err again.
